// File: rtl/regfile_mp.sv
// Multi-ported register file: NRD combinational read ports, two write ports,
// optional hardwired zero register, optional write-through bypass and per-register written flags.
module regfile_mp #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = DEPTH - 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    ReadRegister,
  output logic [NRD*WIDTH-1:0] ReadData,
  input  logic [AW-1:0]        WriteRegister0,
  input  logic [AW-1:0]        WriteRegister1,
  input  logic [WIDTH-1:0]     WriteData0,
  input  logic [WIDTH-1:0]     WriteData1,
  input  logic                 RegWrite0,
  input  logic                 RegWrite1,
  output logic [DEPTH-1:0]     Written
);

  // ZERO_REG == DEPTH (or beyond) means no register is hardwired to zero.
  localparam bit HasZero = (ZERO_REG < DEPTH);

  function automatic logic is_zero(input logic [AW-1:0] addr);
    return HasZero && (32'(addr) == ZERO_REG);
  endfunction

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;

  logic wen0, wen1;
  assign wen0 = RegWrite0 && !is_zero(WriteRegister0);
  assign wen1 = RegWrite1 && !is_zero(WriteRegister1);

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d    = regs_q;
    written_d = written_q;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
      written_d = '0;
    end else begin
      if (wen0) begin
        regs_d[WriteRegister0]    = WriteData0;
        written_d[WriteRegister0] = 1'b1;
      end
      if (wen1) begin
        regs_d[WriteRegister1]    = WriteData1;
        written_d[WriteRegister1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q    <= regs_d;
    written_q <= written_d;
  end

  assign Written = written_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = ReadRegister[k*AW +: AW];

    always_comb begin
      rd = regs_q[ra];
      if ((BYPASS != 0) && !reset) begin
        if (wen0 && (WriteRegister0 == ra)) rd = WriteData0;
        if (wen1 && (WriteRegister1 == ra)) rd = WriteData1;
      end
      if (is_zero(ra)) rd = '0;
    end

    assign ReadData[k*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 64: data width in bits.
REQ-002 Parameter DEPTH, default 32: number of registers, power of two, 4..64; AW = log2(DEPTH).
REQ-003 Parameter NRD, default 2: number of read ports, 1..4.
REQ-004 Parameter ZERO_REG, default DEPTH-1: index hardwired to zero; value DEPTH disables the zero register.
REQ-005 Parameter BYPASS, default 1: 1 = write-through forwarding to reads in the write cycle; 0 = reads return the stored value only.
REQ-006 Port clk  input  1: single clock; all state updates on rising edge.
REQ-007 Port reset  input  1: synchronous, active-high reset.
REQ-008 Port ReadRegister  input  NRD*AW: read addresses; port k occupies bits [k*AW +: AW].
REQ-009 Port ReadData  output  NRD*WIDTH: read data; port k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port WriteRegister0, WriteRegister1  input  AW each: write addresses, ports 0 and 1.
REQ-011 Port WriteData0, WriteData1  input  WIDTH each: write data.
REQ-012 Port RegWrite0, RegWrite1  input  1 each: write enables.
REQ-013 Port Written  output  DEPTH: bit i set once register i has been written since reset.

Function
REQ-014 Storage: DEPTH x WIDTH registers, updated only on the rising edge of clk.
REQ-015 With RegWriteN high on an edge, register WriteRegisterN takes WriteDataN at that edge.
REQ-016 Both ports writing the same address on one edge: port 1 data is stored; port 0 is discarded.
REQ-017 Writes to ZERO_REG are ignored; ReadData for ZERO_REG is always 0 and Written[ZERO_REG] is always 0, regardless of BYPASS.
REQ-018 Reads are combinational: ReadData[k] = register[ReadRegister[k]], with no added cycle latency.
REQ-019 BYPASS=1: when RegWriteN is high and WriteRegisterN equals ReadRegister[k] (not ZERO_REG), ReadData[k] = WriteDataN in the same cycle; port 1 takes priority over port 0.
REQ-020 BYPASS=0: a read of a register being written returns the old value until after the edge.
REQ-021 Written[i] is set on the edge that writes register i and stays set until reset.
REQ-022 All read ports are independent; any number of ports may read the same address in one cycle.
REQ-023 Write addresses are always in range because DEPTH is a power of two.

Reset
REQ-024 reset high at a rising edge clears every register to 0 and Written to 0 on that edge.
REQ-025 reset overrides RegWrite0/1 on the same edge; no write takes effect.
REQ-026 During the reset cycle, ReadData shows the pre-edge contents; BYPASS forwarding is suppressed while reset is high.
REQ-027 reset asserted in the middle of a write sequence discards the pending write; writing resumes on the first edge with reset low.

Verification
REQ-028 Zero register: RegWrite0=1, WriteRegister0=31, WriteData0=0xA0, then read port 0 at address 31 -> ReadData[0]=0 and Written[31]=0.
REQ-029 Pattern: write i*0x0000010204080001 to registers 0..30 using alternating ports, then read all 32 addresses on every read port -> each register returns its pattern, register 31 returns 0, and Written=0x7FFFFFFF.
REQ-030 Dual write collision: write 0x1111111111111111 via port 0 and 0x2222222222222222 via port 1 to register 10 on the same edge -> register 10 reads 0x2222222222222222.
REQ-031 Bypass: BYPASS=1, write 0x123456789ABCDEF0 to register 5 while reading 5 -> ReadData shows the new value before the edge; with BYPASS=0, it shows the old value until after the edge.
REQ-032 Reset mid-operation: load registers 0..3, assert reset for one edge with RegWrite0=1 to register 2 -> all reads return 0, Written=0, and register 2 remains 0.
REQ-033 Parameter sweep: WIDTH=32, DEPTH=16, NRD=4, ZERO_REG=16 (zero register disabled) -> register 15 stores and returns 0xDEADBEEF, and all four read ports agree.
